// File: rtl/parc_mem_arbiter.sv
// rtl/parc_mem_arbiter.sv - two-port round-robin memory arbiter with in-order response routing
module parc_mem_arbiter #(
  parameter  int DEPTH   = 4,
  parameter  int REQ_SZ  = 67,
  parameter  int RESP_SZ = 35,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,

  input  logic [REQ_SZ-1:0]  req0_msg,
  input  logic               req0_val,
  output logic               req0_rdy,

  input  logic [REQ_SZ-1:0]  req1_msg,
  input  logic               req1_val,
  output logic               req1_rdy,

  output logic [RESP_SZ-1:0] resp0_msg,
  output logic               resp0_val,

  output logic [RESP_SZ-1:0] resp1_msg,
  output logic               resp1_val,

  output logic [REQ_SZ-1:0]  memreq_msg,
  output logic               memreq_val,
  input  logic               memreq_rdy,

  input  logic [RESP_SZ-1:0] memresp_msg,
  input  logic               memresp_val,

  output logic [CNT_W-1:0]   outstanding,
  output logic               err
);

  // Owner FIFO: one bit per in-flight request recording which port issued it
  logic [DEPTH-1:0] own_q, own_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Arbitration state
  logic lock_q, lock_d;
  logic lock_id_q, lock_id_d;
  logic last_grant_q, last_grant_d;
  logic err_q, err_d;

  // Combinational control
  logic grant;
  logic grant_v;
  logic grant_val;
  logic full;
  logic empty;
  logic fire;
  logic push;
  logic pop;
  logic unexpected;
  logic head;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = own_q[rptr_q];

  // Grant selection: a stalled presented request keeps the grant, otherwise round-robin on ties
  always_comb begin
    grant   = 1'b0;
    grant_v = 1'b1;
    if (lock_q) begin
      grant = lock_id_q;
    end else if (req0_val && !req1_val) begin
      grant = 1'b0;
    end else if (req1_val && !req0_val) begin
      grant = 1'b1;
    end else if (req0_val && req1_val) begin
      grant = ~last_grant_q;
    end else begin
      grant_v = 1'b0;
    end
  end

  assign grant_val  = grant ? req1_val : req0_val;

  // Request steering: granted port drives the shared port, blocked entirely while full
  always_comb begin
    memreq_msg = grant ? req1_msg : req0_msg;
    memreq_val = grant_v && grant_val && !full;
    req0_rdy   = grant_v && (grant == 1'b0) && memreq_rdy && !full;
    req1_rdy   = grant_v && (grant == 1'b1) && memreq_rdy && !full;
  end

  assign fire       = memreq_val && memreq_rdy;
  assign push       = fire;
  assign pop        = memresp_val && !empty;
  assign unexpected = memresp_val && empty;

  // Response routing: the FIFO head names the port that owns the returning response
  always_comb begin
    resp0_msg = memresp_msg;
    resp1_msg = memresp_msg;
    resp0_val = pop && (head == 1'b0);
    resp1_val = pop && (head == 1'b1);
  end

  // Owner FIFO next state: pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    own_d  = own_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      own_d[wptr_q] = grant;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
  end

  // Outstanding count next state: simultaneous push and pop leaves it unchanged
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Lock and round-robin next state: a refused request pins the grant until it fires
  always_comb begin
    lock_d       = lock_q;
    lock_id_d    = lock_id_q;
    last_grant_d = last_grant_q;
    if (fire) begin
      lock_d       = 1'b0;
      last_grant_d = grant;
    end else if (memreq_val && !memreq_rdy) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end
  end

  // Error flag next state: sticky once a response arrives with nothing outstanding
  always_comb begin
    err_d = err_q | unexpected;
  end

  // FIFO and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      own_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      own_q  <= own_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Arbitration and error registers; last_grant resets to 1 so port 0 wins the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q       <= 1'b0;
      lock_id_q    <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_id_q    <= lock_id_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  assign outstanding = cnt_q;
  assign err         = err_q;

endmodule
